// File: rtl/frog_pkg.sv
// Shared types and default geometry for the frog game's collision and lane logic.
package frog_pkg;

  localparam int LANES_DEF = 8;
  localparam int COLS_DEF  = 16;
  localparam int LIVES_W   = 4;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HOLDOFF = 2'd1,
    DEAD    = 2'd2
  } collide_state_t;

endpackage

// File: rtl/holdoff_timer.sv
// Free-running hold-off counter with synchronous clear; done flags the all-ones count.
module holdoff_timer #(
  parameter int WIDTH = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done_o = &count_q;

endmodule

// File: rtl/frog_collision.sv
// Frog collision detector and lives tracker; FROG_COLLIDE_HOLDOFF_EN selects a timed
// hold-off, otherwise hold-off lasts until the frog stops overlapping a car.
module frog_collision
  import frog_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int LIVES     = 3,
  parameter int HOLDOFF_W = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES*COLS-1:0]      lane_pixels,
  input  logic [$clog2(LANES)-1:0]   frog_row,
  input  logic [$clog2(COLS)-1:0]    frog_col,
  input  logic                       frog_in_road,
  output logic [LANES-1:0]           hit,
  output logic [LIVES_W-1:0]         lives,
  output logic                       collide_pulse,
  output logic                       game_over
);

  localparam int ROW_W = $clog2(LANES);
  localparam int ROWS  = 2 ** ROW_W;

  collide_state_t     state_q;
  logic [LIVES_W-1:0] lives_q;
  logic               pulse_q;
  logic               game_over_q;

  logic [COLS-1:0] rows [ROWS];
  logic            row_ok;
  logic            overlap;
  logic            collide;
  logic            holdoff_exit;

  // Rows past LANES read as empty so a non-power-of-two lane count never aliases.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    if (i < LANES) begin : g_real
      assign rows[i] = lane_pixels[i*COLS +: COLS];
    end else begin : g_pad
      assign rows[i] = '0;
    end
  end

  assign row_ok  = {1'b0, frog_row} < (ROW_W + 1)'(LANES);
  assign overlap = frog_in_road & row_ok & rows[frog_row][frog_col];
  assign collide = (state_q == ARMED) & overlap & (lives_q != '0);

`ifdef FROG_COLLIDE_HOLDOFF_EN
  logic timer_done;

  holdoff_timer #(
    .WIDTH (HOLDOFF_W)
  ) u_holdoff_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (collide),
    .en_i   (state_q == HOLDOFF),
    .done_o (timer_done)
  );

  assign holdoff_exit = timer_done;
`else
  assign holdoff_exit = ~overlap;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARMED;
      lives_q     <= LIVES_W'(LIVES);
      pulse_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ARMED: begin
          if (collide) begin
            lives_q <= lives_q - 1'b1;
            pulse_q <= 1'b1;
            if (lives_q == LIVES_W'(1)) begin
              state_q     <= DEAD;
              game_over_q <= 1'b1;
            end else begin
              state_q <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (holdoff_exit) state_q <= ARMED;
        end
        DEAD: begin
          game_over_q <= 1'b1;
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  assign lives         = lives_q;
  assign collide_pulse = pulse_q;
  assign game_over     = game_over_q;
  assign hit           = {LANES{game_over_q}};

endmodule

// File: tb/tb_frog_collision.sv
// Directed self-checking bench for frog_collision; sequence follows FROG_COLLIDE_HOLDOFF_EN.
module tb_frog_collision;

  localparam int LANES     = 8;
  localparam int COLS      = 16;
  localparam int LIVES     = 3;
  localparam int HOLDOFF_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [LANES*COLS-1:0] lane_pixels;
  logic [2:0]            frog_row;
  logic [3:0]            frog_col;
  logic                  frog_in_road;
  logic [LANES-1:0]      hit;
  logic [3:0]            lives;
  logic                  collide_pulse;
  logic                  game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  frog_collision #(
    .LANES     (LANES),
    .COLS      (COLS),
    .LIVES     (LIVES),
    .HOLDOFF_W (HOLDOFF_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lane_pixels   (lane_pixels),
    .frog_row      (frog_row),
    .frog_col      (frog_col),
    .frog_in_road  (frog_in_road),
    .hit           (hit),
    .lives         (lives),
    .collide_pulse (collide_pulse),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (collide_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic frog_on_car(input bit on);
    lane_pixels = '0;
    frog_row = 3'd2;
    frog_col = 4'd5;
    frog_in_road = 1'b1;
    if (on) lane_pixels[2*COLS + 5] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("reset_lives", 32'(lives), 32'd3);
    check("reset_hit", 32'(hit), 32'h00);
    check("reset_game_over", 32'(game_over), 32'd0);
    check("reset_pulse", 32'(collide_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
  endtask

  initial begin
    reset = 1'b1;
    frog_on_car(1'b0);
    frog_in_road = 1'b0;
    pulses = 0;
    #3;
    do_reset();

    // Idle road for 50 cycles.
    step(50);
    check("idle_lives", 32'(lives), 32'd3);
    check("idle_hit", 32'(hit), 32'h00);
    check("idle_no_pulse", 32'(pulses), 32'd0);

    // Single-cycle overlap at row 2 col 5.
    frog_on_car(1'b1);
    step();
    frog_on_car(1'b0);
    check("single_lives", 32'(lives), 32'd2);
    check("single_pulse_hi", 32'(collide_pulse), 32'd1);
    check("single_hit", 32'(hit), 32'h00);
    step();
    check("single_pulse_lo", 32'(collide_pulse), 32'd0);
    step(20);
    check("single_one_pulse", 32'(pulses), 32'd1);

    // Masked overlaps: off the road, and row 7 clear with row 6 full.
    frog_on_car(1'b1);
    frog_in_road = 1'b0;
    step(5);
    check("off_road_lives", 32'(lives), 32'd2);
    lane_pixels = '0;
    lane_pixels[6*COLS +: COLS] = 16'hFFFF;
    frog_row = 3'd7;
    frog_col = 4'd5;
    frog_in_road = 1'b1;
    step(5);
    check("row7_lives", 32'(lives), 32'd2);
    frog_row = 3'd6;
    frog_col = 4'd15;
    step();
    check("row6_col15_lives", 32'(lives), 32'd1);
    frog_on_car(1'b0);
    step(20);

`ifdef FROG_COLLIDE_HOLDOFF_EN
    // Reset in the middle of hold-off.
    do_reset();
    frog_on_car(1'b1);
    step();
    frog_on_car(1'b0);
    check("ho_first_lives", 32'(lives), 32'd2);
    step(8);
    #2;
    reset = 1'b0;
    #1;
    check("ho_reset_lives", 32'(lives), 32'd3);
    check("ho_reset_hit", 32'(hit), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    frog_on_car(1'b1);
    step();
    check("ho_rearm_lives", 32'(lives), 32'd2);
    check("ho_rearm_pulse", 32'(collide_pulse), 32'd1);
    frog_on_car(1'b0);

    // Persistent overlap: a life every 17 cycles.
    do_reset();
    frog_on_car(1'b1);
    for (int c = 1; c <= 40; c++) begin
      step();
      case (c)
        1:  begin check("hold_c1_lives", 32'(lives), 32'd2); check("hold_c1_pulse", 32'(collide_pulse), 32'd1); end
        2:  check("hold_c2_pulse", 32'(collide_pulse), 32'd0);
        17: check("hold_c17_lives", 32'(lives), 32'd2);
        18: begin check("hold_c18_lives", 32'(lives), 32'd1); check("hold_c18_hit", 32'(hit), 32'h00); end
        34: check("hold_c34_lives", 32'(lives), 32'd1);
        35: begin
          check("hold_c35_lives", 32'(lives), 32'd0);
          check("hold_c35_go", 32'(game_over), 32'd1);
          check("hold_c35_hit", 32'(hit), 32'hFF);
        end
        default: ;
      endcase
    end
    check("hold_pulse_count", 32'(pulses), 32'd3);
`else
    // Reset while held in the release-rule hold-off.
    do_reset();
    frog_on_car(1'b1);
    step();
    check("rel_first_lives", 32'(lives), 32'd2);
    step(3);
    #2;
    reset = 1'b0;
    #1;
    check("rel_reset_lives", 32'(lives), 32'd3);
    check("rel_reset_hit", 32'(hit), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rel_rearm_lives", 32'(lives), 32'd2);
    check("rel_rearm_pulse", 32'(collide_pulse), 32'd1);

    // Overlap held 100 cycles costs one life; each re-entry costs another.
    do_reset();
    frog_on_car(1'b1);
    step();
    check("rel_c1_lives", 32'(lives), 32'd2);
    check("rel_c1_pulse", 32'(collide_pulse), 32'd1);
    step(99);
    check("rel_held_lives", 32'(lives), 32'd2);
    check("rel_held_pulses", 32'(pulses), 32'd1);
    frog_on_car(1'b0);
    step();
    check("rel_release_lives", 32'(lives), 32'd2);
    frog_on_car(1'b1);
    step();
    check("rel_again_lives", 32'(lives), 32'd1);
    check("rel_again_pulse", 32'(collide_pulse), 32'd1);
    check("rel_again_hit", 32'(hit), 32'h00);
    frog_on_car(1'b0);
    step();
    frog_on_car(1'b1);
    step();
    check("rel_last_lives", 32'(lives), 32'd0);
    check("rel_last_go", 32'(game_over), 32'd1);
    check("rel_last_hit", 32'(hit), 32'hFF);
`endif

    // Game over is sticky and lives never underflow.
    frog_on_car(1'b0);
    step(3);
    frog_on_car(1'b1);
    step(5);
    frog_on_car(1'b0);
    step(3);
    check("dead_lives", 32'(lives), 32'd0);
    check("dead_go", 32'(game_over), 32'd1);
    check("dead_hit", 32'(hit), 32'hFF);
    check("dead_pulse", 32'(collide_pulse), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
